tanh_lut_loader: RTL and testbench

TANH_LUT_LOADER -- requirements
Module: tanh_lut_loader

---
 rtl/tanh_lut_loader.sv | 105 ++++++++++
 tb/tb_tanh_lut_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tanh_lut_loader.sv
// tanh_lut_loader: streams DEPTH source words into the tanh LUT, one registered write per accepted word.
// Define TANH_LUT_CHECKSUM_EN to add a trailing checksum word that is verified against the sum of all loaded entries.
module tanh_lut_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  lut_we,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  output logic [DATA_WIDTH-1:0] lut_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  we_q, busy_q, done_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
`ifdef TANH_LUT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif
  assign cnt_d        = cnt_q + 1'b1;
  assign last_d       = &cnt_q[ADDR_WIDTH-1:0];
  assign s_ready      = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign lut_we       = we_q;
  assign lut_addr     = addr_q;
  assign lut_wdata    = wdata_q;
  assign words_loaded = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TANH_LUT_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
`ifdef TANH_LUT_CHECKSUM_EN
          acc_q   <= '0;
          err_q   <= 1'b0;
`endif
        end
        // abort beats a same-cycle acceptance, so nothing is written
        LOAD: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (s_valid) begin
          we_q    <= 1'b1;
          addr_q  <= cnt_q[ADDR_WIDTH-1:0];
          wdata_q <= s_data;
          cnt_q   <= cnt_d;
`ifdef TANH_LUT_CHECKSUM_EN
          acc_q   <= acc_q + s_data;
          if (last_d) state_q <= CHECK;
`else
          if (last_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`endif
        end
`ifdef TANH_LUT_CHECKSUM_EN
        CHECK: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (s_valid) begin
          err_q   <= s_data != acc_q;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tanh_lut_loader.sv
// tb_tanh_lut_loader: directed and randomized loads checked cycle by cycle against a behavioural loader model.
module tb_tanh_lut_loader;
  localparam int DEPTH = 512;
`ifdef TANH_LUT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, lut_we, busy, done, error;
  logic [8:0]  lut_addr;
  logic [15:0] lut_wdata;
  logic [9:0]  words_loaded;
  int          errors = 0, checks = 0;
  int          m_ph = 0, m_cnt = 0;
  logic [15:0] m_sum = '0;
  logic        m_err = 1'b0;

  tanh_lut_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_lut_we"}, lut_we, 0);
    chk({tag, "_lut_addr"}, lut_addr, 0);
    chk({tag, "_lut_wdata"}, lut_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words_loaded"}, words_loaded, 0);
    m_ph = 0; m_cnt = 0; m_sum = '0; m_err = 1'b0;
  endtask

  // phases: 0 idle, 1 loading entries, 2 awaiting checksum, 3 done pulse
  task automatic cyc(input logic v, input logic [15:0] d, input logic st, input logic ab);
    logic       ew;
    logic [8:0] ea;
    chk("s_ready", s_ready, m_ph == 1 || m_ph == 2);
    s_valid = v; s_data = d; start = st; abort = ab;
    @(posedge clk); #1;
    ew = 1'b0;
    ea = 9'(m_cnt);
    case (m_ph)
      0: if (st) begin m_ph = 1; m_cnt = 0; m_sum = '0; m_err = 1'b0; end
      1: if (ab) m_ph = 0;
         else if (v) begin
           ew = 1'b1; m_sum = m_sum + d; m_cnt++;
           if (m_cnt == DEPTH) m_ph = CK ? 2 : 3;
         end
      2: if (ab) m_ph = 0;
         else if (v) begin m_err = (d != m_sum); m_ph = 3; end
      default: m_ph = 0;
    endcase
    chk("lut_we", lut_we, ew);
    if (ew) begin
      chk("lut_addr", lut_addr, ea);
      chk("lut_wdata", lut_wdata, d);
    end
    chk("done", done, m_ph == 3);
    chk("busy", busy, m_ph == 1 || m_ph == 2);
    chk("words_loaded", words_loaded, m_cnt);
    chk("error", error, m_err);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    // full continuous load with start pulses that must be ignored
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), i % 97 == 50, 1'b0);
    if (CK) cyc(1'b1, 16'hFF00, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("wl_full", words_loaded, DEPTH);
    chk("err_good_sum", error, 0);
    // s_valid every other cycle, then a bad checksum
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int k = 0; k < 2 * DEPTH; k++)
      cyc(k % 2 == 0, (k % 2 == 0) ? 16'(k / 2) : 16'($urandom), 1'b0, 1'b0);
    if (CK) cyc(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'($urandom), 16'($urandom), 1'b0, 1'b0);
    chk("wl_toggle", words_loaded, DEPTH);
    chk("err_bad_sum", error, CK);
    // random stall pattern, abort on word 100
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("err_cleared", error, 0);
    for (int k = 0; k < 1000 && m_cnt < 100; k++) cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'($urandom), 16'($urandom), 1'b0, 1'b0);
    chk("wl_abort", words_loaded, 100);
    chk("busy_abort", busy, 0);
    // asynchronous reset in the middle of a load
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 16'd300;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midload_reset");
    @(negedge clk) rst_n = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("wl_reload", words_loaded, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
